// File: rtl/vga_timing_pkg.sv
// Shared constants, state encoding and line/frame total helpers for the VGA raster generator.
// Defaults describe 640x480@60 with a 25 MHz pixel clock.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE     = 640;
  localparam int DEF_H_FP         = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BP         = 48;
  localparam int DEF_V_ACTIVE     = 480;
  localparam int DEF_V_FP         = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BP         = 33;
  localparam int DEF_LOCK_HOLDOFF = 256;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLDOFF   = 2'd1,
    RUN       = 2'd2
  } lock_state_t;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return calc_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return calc_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/lock_qualifier.sv
// Synchronises the PLL lock flag and only grants run_en once lock has held for LOCK_HOLDOFF
// consecutive cycles; any dropout restarts the qualification from scratch.
module lock_qualifier
  import vga_timing_pkg::*;
#(
  parameter int LOCK_HOLDOFF = DEF_LOCK_HOLDOFF
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked,
  output logic run_en
);

  localparam int CW = $clog2(LOCK_HOLDOFF);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_HOLDOFF - 1);

  logic          r_sync1;
  logic          r_lock_s;
  logic [CW-1:0] r_cnt;
  logic          r_run_en;
  lock_state_t   r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
      r_cnt    <= '0;
      r_run_en <= 1'b0;
      r_state  <= WAIT_LOCK;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
      case (r_state)
        WAIT_LOCK: begin
          r_cnt <= '0;
          if (r_lock_s) begin
            r_state <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (!r_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state  <= RUN;
            r_run_en <= 1'b1;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!r_lock_s) begin
            r_state  <= WAIT_LOCK;
            r_run_en <= 1'b0;
          end
        end
        default: begin
          r_state  <= WAIT_LOCK;
          r_run_en <= 1'b0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign run_en = r_run_en;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter plus registered sync/DE/RGB outputs; pulls one pixel per active position
// from a valid/ready stream and blanks (flagging underflow) when the stream runs dry.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int LOCK_HOLDOFF = DEF_LOCK_HOLDOFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [23:0] vga_rgb,
  output logic        sof,
  output logic        underflow
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic          w_run_en;
  logic          w_active;
  logic          w_hs_n;
  logic          w_vs_n;
  logic [HW-1:0] r_h_cnt;
  logic [VW-1:0] r_v_cnt;
  logic          r_hs;
  logic          r_vs;
  logic          r_de;
  logic [23:0]   r_rgb;
  logic          r_sof;
  logic          r_underflow;

  lock_qualifier #(
    .LOCK_HOLDOFF(LOCK_HOLDOFF)
  ) u_lock_qualifier (
    .clk       (clk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .run_en    (w_run_en)
  );

  // Counters sit at (0,0) whenever not running, so every RUN entry starts a fresh frame.
  always_ff @(posedge clk) begin
    if (rst || !w_run_en) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST_C) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST_C) ? '0 : r_v_cnt + 1'b1;
    end else begin
      r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign w_active  = w_run_en && (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);
  assign w_hs_n    = !(w_run_en && (r_h_cnt >= HS_BEG_C) && (r_h_cnt < HS_END_C));
  assign w_vs_n    = !(w_run_en && (r_v_cnt >= VS_BEG_C) && (r_v_cnt < VS_END_C));
  assign pix_ready = w_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_de        <= 1'b0;
      r_rgb       <= '0;
      r_sof       <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_hs  <= w_hs_n;
      r_vs  <= w_vs_n;
      r_de  <= w_active;
      r_rgb <= (w_active && pix_valid) ? pix_data : 24'd0;
      r_sof <= w_run_en && (r_h_cnt == '0) && (r_v_cnt == '0);
      if (w_active && !pix_valid) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign vga_hs    = r_hs;
  assign vga_vs    = r_vs;
  assign vga_de    = r_de;
  assign vga_rgb   = r_rgb;
  assign sof       = r_sof;
  assign underflow = r_underflow;

endmodule
